// File: rtl/nibble_pkg.sv
// Shared types and widths for the nibble subtract sequencer and its
// combinational subtractor.
package nibble_pkg;

    localparam int NIB_W = 4;
    localparam int RES_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_sub4.sv
// Combinational 4-bit subtractor: r = {borrow, (x - y) mod 16}.
module nibble_sub4
    import nibble_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    output logic [RES_W-1:0] r
);

    // A 5-bit subtraction of zero-extended operands yields the borrow in bit 4.
    assign r = {1'b0, x} - {1'b0, y};

endmodule

// File: rtl/nibble_sub_seq.sv
// Accepts a byte pair, then streams the two per-nibble differences as two
// 5-bit beats, ordered by ctrl, with a count of fully emitted pairs.
module nibble_sub_seq
    import nibble_pkg::*;
#(
    parameter int COUNT_W = 8
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         A,
    input  logic [7:0]         B,
    input  logic               ctrl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RES_W-1:0]   q,
    output logic               q_last,
    output logic [COUNT_W-1:0] pair_count
);

    state_t             state_r, state_s;
    logic [7:0]         a_r, a_s;
    logic [7:0]         b_r, b_s;
    logic               ctrl_r, ctrl_s;
    logic [RES_W-1:0]   q_r, q_s;
    logic               q_last_r, q_last_s;
    logic               out_valid_r, out_valid_s;
    logic [COUNT_W-1:0] pair_count_r, pair_count_s;
    logic [NIB_W-1:0]   x_s, y_s;
    logic [RES_W-1:0]   r_s;

    nibble_sub4 u_sub (
        .x (x_s),
        .y (y_s),
        .r (r_s)
    );

    // Operand select: IDLE feeds the incoming first-order nibble, later states
    // feed the second-order nibble of the captured pair.
    always_comb begin
        x_s = a_r[3:0];
        y_s = b_r[3:0];
        if (state_r == IDLE) begin
            if (ctrl) begin
                x_s = A[7:4];
                y_s = B[7:4];
            end else begin
                x_s = A[3:0];
                y_s = B[3:0];
            end
        end else begin
            if (ctrl_r) begin
                x_s = a_r[3:0];
                y_s = b_r[3:0];
            end else begin
                x_s = a_r[7:4];
                y_s = b_r[7:4];
            end
        end
    end

    // Next-state and next-output decode for the handshake FSM.
    always_comb begin
        state_s      = state_r;
        a_s          = a_r;
        b_s          = b_r;
        ctrl_s       = ctrl_r;
        q_s          = q_r;
        q_last_s     = q_last_r;
        out_valid_s  = out_valid_r;
        pair_count_s = pair_count_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    a_s         = A;
                    b_s         = B;
                    ctrl_s      = ctrl;
                    q_s         = r_s;
                    q_last_s    = 1'b0;
                    out_valid_s = 1'b1;
                    state_s     = FIRST;
                end else begin
                    out_valid_s = 1'b0;
                end
            end
            FIRST: begin
                if (out_ready) begin
                    q_s      = r_s;
                    q_last_s = 1'b1;
                    state_s  = SECOND;
                end else begin
                    state_s = FIRST;
                end
            end
            SECOND: begin
                if (out_ready) begin
                    out_valid_s  = 1'b0;
                    q_last_s     = 1'b0;
                    pair_count_s = pair_count_r + COUNT_W'(1);
                    state_s      = IDLE;
                end else begin
                    state_s = SECOND;
                end
            end
            default: begin
                out_valid_s = 1'b0;
                q_last_s    = 1'b0;
                state_s     = IDLE;
            end
        endcase
    end

    // State and output registers; rst overrides any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            a_r          <= 8'h00;
            b_r          <= 8'h00;
            ctrl_r       <= 1'b0;
            q_r          <= 5'h00;
            q_last_r     <= 1'b0;
            out_valid_r  <= 1'b0;
            pair_count_r <= '0;
        end else begin
            state_r      <= state_s;
            a_r          <= a_s;
            b_r          <= b_s;
            ctrl_r       <= ctrl_s;
            q_r          <= q_s;
            q_last_r     <= q_last_s;
            out_valid_r  <= out_valid_s;
            pair_count_r <= pair_count_s;
        end
    end

    assign in_ready   = (state_r == IDLE);
    assign out_valid  = out_valid_r;
    assign q          = q_r;
    assign q_last     = q_last_r;
    assign pair_count = pair_count_r;

endmodule

// File: tb/tb_nibble_sub_seq.sv
// Directed and randomized self-checking bench for nibble_sub_seq.
module tb_nibble_sub_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic       ctrl;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] q;
    logic       q_last;
    logic [7:0] pair_count;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] model_pc;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [4:0] e1;
        logic [4:0] e2;
    } vec_t;

    vec_t vecs [8];
    logic [5:0] exp_q [$];

    always #5 clk = ~clk;

    nibble_sub_seq #(.COUNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .ctrl       (ctrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .q          (q),
        .q_last     (q_last),
        .pair_count (pair_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ref_sub(input logic [3:0] x, input logic [3:0] y);
        int d;
        d = (int'(x) + 16 - int'(y)) % 16;
        return {(int'(x) < int'(y)), d[3:0]};
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_pc = 8'h00;
    endtask

    // One full pair with out_ready held high; operands are scrambled after accept.
    task automatic do_pair(input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic [4:0] e1, input logic [4:0] e2, input string tag);
        @(negedge clk);
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; A = a; B = b; ctrl = c; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; A = ~a; B = ~b; ctrl = ~c;
        check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
        check({tag, " beat1 valid"}, 32'(out_valid), 32'd1);
        check({tag, " beat1 q"}, 32'(q), 32'(e1));
        check({tag, " beat1 last"}, 32'(q_last), 32'd0);
        @(negedge clk);
        check({tag, " beat2 q"}, 32'(q), 32'(e2));
        check({tag, " beat2 last"}, 32'(q_last), 32'd1);
        @(negedge clk);
        model_pc = model_pc + 8'd1;
        check({tag, " end valid"}, 32'(out_valid), 32'd0);
        check({tag, " end in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " pair_count"}, 32'(pair_count), 32'(model_pc));
    endtask

    initial begin
        int beats;
        int accepted;
        int cycles;
        logic [5:0] head;
        logic [7:0] ra, rb;
        logic       rc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = 8'h00; B = 8'h00; ctrl = 1'b0;
        model_pc = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset q", 32'(q), 32'd0);
        check("reset q_last", 32'(q_last), 32'd0);
        check("reset pair_count", 32'(pair_count), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);

        vecs[0] = '{a: 8'h35, b: 8'h19, c: 1'b0, e1: 5'h1C, e2: 5'h02};
        vecs[1] = '{a: 8'h35, b: 8'h19, c: 1'b1, e1: 5'h02, e2: 5'h1C};
        vecs[2] = '{a: 8'hFF, b: 8'h00, c: 1'b0, e1: 5'h0F, e2: 5'h0F};
        vecs[3] = '{a: 8'h00, b: 8'hFF, c: 1'b1, e1: 5'h11, e2: 5'h11};
        vecs[4] = '{a: 8'h7A, b: 8'h7A, c: 1'b0, e1: 5'h00, e2: 5'h00};
        vecs[5] = '{a: 8'h8C, b: 8'h3D, c: 1'b0, e1: 5'h1F, e2: 5'h05};
        vecs[6] = '{a: 8'h8C, b: 8'h3D, c: 1'b1, e1: 5'h05, e2: 5'h1F};
        vecs[7] = '{a: 8'h10, b: 8'h01, c: 1'b1, e1: 5'h01, e2: 5'h1F};
        for (int i = 0; i < 8; i++)
            do_pair(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].e1, vecs[i].e2,
                    $sformatf("vec%0d", i));

        // Backpressure: beat 1 held for 5 stalled cycles, stray in_valid ignored.
        beats = 0;
        @(negedge clk);
        in_valid = 1'b1; A = 8'hF0; B = 8'h0F; ctrl = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = i[0]; A = 8'h00; B = 8'h00;
            check("stall q", 32'(q), 32'h11);
            check("stall last", 32'(q_last), 32'd0);
            check("stall valid", 32'(out_valid), 32'd1);
            check("stall in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        check("stall end q", 32'(q), 32'h11);
        in_valid = 1'b0; out_ready = 1'b1;
        if (out_valid && out_ready) beats++;
        @(negedge clk);
        check("bp beat2 q", 32'(q), 32'h0F);
        check("bp beat2 last", 32'(q_last), 32'd1);
        if (out_valid && out_ready) beats++;
        @(negedge clk);
        if (out_valid && out_ready) beats++;
        model_pc = model_pc + 8'd1;
        check("bp beat count", 32'(beats), 32'd2);
        check("bp in_ready", 32'(in_ready), 32'd1);
        check("bp pair_count", 32'(pair_count), 32'(model_pc));

        // Equal operands and counter wrap.
        pulse_reset();
        for (int i = 0; i < 256; i++)
            do_pair(8'hAA, 8'hAA, i[0], 5'h00, 5'h00, "wrap");
        check("wrap final count", 32'(pair_count), 32'd0);

        // Reset mid-pair while in FIRST.
        @(negedge clk);
        in_valid = 1'b1; A = 8'h12; B = 8'h34; ctrl = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("abort first q", 32'(q), 32'h1E);
        rst = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; model_pc = 8'h00;
        check("abort valid", 32'(out_valid), 32'd0);
        check("abort q", 32'(q), 32'd0);
        check("abort pair_count", 32'(pair_count), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        beats = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid || q_last) beats++;
        end
        check("abort no beats", 32'(beats), 32'd0);

        // Randomized traffic against a queue scoreboard.
        pulse_reset();
        accepted = 0;
        cycles = 0;
        while ((accepted < 1000 || exp_q.size() > 0) && cycles < 30000) begin
            @(negedge clk);
            check("rand pair_count", 32'(pair_count), 32'(model_pc));
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            in_valid = (accepted < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            A = ra; B = rb; ctrl = rc;
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand unexpected beat", 32'(out_valid), 32'd0);
                end else begin
                    head = exp_q.pop_front();
                    check("rand q", 32'(q), 32'(head[4:0]));
                    check("rand q_last", 32'(q_last), 32'(head[5]));
                    if (head[5]) model_pc = model_pc + 8'd1;
                end
            end
            if (in_ready && in_valid) begin
                accepted++;
                if (rc) begin
                    exp_q.push_back({1'b0, ref_sub(ra[7:4], rb[7:4])});
                    exp_q.push_back({1'b1, ref_sub(ra[3:0], rb[3:0])});
                end else begin
                    exp_q.push_back({1'b0, ref_sub(ra[3:0], rb[3:0])});
                    exp_q.push_back({1'b1, ref_sub(ra[7:4], rb[7:4])});
                end
            end
            cycles++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("rand accepted", 32'(accepted), 32'd1000);
        check("rand drained", 32'(exp_q.size()), 32'd0);
        check("rand final count", 32'(pair_count), 32'(model_pc));
        check("rand final count abs", 32'(pair_count), 32'(1000 % 256));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
